// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds a trailing parity slot to every frame.
package tdm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Wide enough to hold the parity slot index as well as NUM_CH-1.
  function automatic int cnt_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Slot index tracker: loads 1 on start-of-frame, steps per accepted beat, clears on frame completion.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int CW   = cnt_width(4),
  parameter int LAST = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_one,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] slot_cnt,
  output logic          is_last
);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;

  // A start-of-frame beat always wins: it is slot 0, so the next slot is 1.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    if (load_one) begin
      slot_cnt_d = CW'(1);
    end else if (clr) begin
      slot_cnt_d = '0;
    end else if (inc) begin
      slot_cnt_d = slot_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign slot_cnt = slot_cnt_q;
  assign is_last  = (slot_cnt_q == CW'(LAST));

endmodule

// File: rtl/tdm_demux.sv
// Serial slot stream to parallel frame word, 1 cycle from final beat to out_valid; in_ready drops only
// while a completing beat finds the output register full. TDM_DEMUX_PARITY_EN adds a parity slot and parity_err.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int W      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_CH*W-1:0] out_data,
  output logic                sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int LAST = PARITY_EN ? NUM_CH : NUM_CH - 1;
  localparam int CW   = cnt_width(NUM_CH);
  localparam int SHW  = LAST * W;

  state_e                state_q, state_d;
  logic [SHW-1:0]        shadow_q, shadow_d;
  logic [NUM_CH*W-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic [CW-1:0]         slot_cnt;
  logic [CW-1:0]         wr_idx;
  logic                  is_last;
  logic                  in_collect, accept, load_one, resync, complete, pop;
  logic [NUM_CH*W-1:0]   frame_word;

  assign in_collect = (state_q == COLLECT);
  assign in_ready   = !(in_collect && is_last && out_valid_q && !out_ready);
  assign accept     = in_valid && in_ready;
  assign load_one   = accept && in_sof;
  assign resync     = load_one && in_collect;
  assign complete   = accept && !in_sof && in_collect && is_last;
  assign pop        = out_valid_q && out_ready;

  tdm_slot_counter #(
    .CW   (CW),
    .LAST (LAST)
  ) u_slot_counter (
    .clk      (clk),
    .rst      (rst),
    .load_one (load_one),
    .inc      (accept && in_collect),
    .clr      (complete),
    .slot_cnt (slot_cnt),
    .is_last  (is_last)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_err_q, parity_err_d;

  // The final beat carries only parity, so the word is entirely shadow data.
  assign frame_word   = shadow_q;
  assign parity_err_d = complete ? (in_data[0] != ~^shadow_q) : parity_err_q;
  assign parity_err   = parity_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
`else
  assign frame_word = {in_data, shadow_q};
`endif

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sync_err_d  = resync;
    wr_idx      = in_sof ? '0 : slot_cnt;

    case (state_q)
      IDLE:    if (load_one) state_d = COLLECT;
      COLLECT: if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Beats dropped while hunting for sof never touch the shadow registers.
    if (accept && (in_sof || in_collect) && !complete) begin
      for (int i = 0; i < LAST; i++) begin
        if (wr_idx == CW'(i)) shadow_d[i*W +: W] = in_data;
      end
    end

    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = frame_word;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table, reset/parity sequences, then random traffic vs a frame-level model.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int W      = 1;
  localparam int DW     = NUM_CH * W;
  localparam int NSLOTS = PARITY_EN ? NUM_CH + 1 : NUM_CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sof;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          sync_err;
  logic          parity_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux #(.NUM_CH(NUM_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sync_err  (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

`ifndef TDM_DEMUX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: a list of slots collected since the last sof.
  logic [W-1:0]  m_frame[$];
  bit            m_coll;
  bit            m_vld;
  logic [DW-1:0] m_dat;
  bit            m_sync;
  bit            m_perr;

  function automatic bit m_ready(input bit ordy);
    return !(m_coll && (m_frame.size() == NSLOTS - 1) && m_vld && !ordy);
  endfunction

  task automatic m_reset();
    m_frame.delete();
    m_coll = 0;
    m_vld  = 0;
    m_dat  = '0;
    m_sync = 0;
    m_perr = 0;
  endtask

  task automatic m_step(input bit vld, input bit sof, input logic [W-1:0] dat, input bit ordy);
    bit            acc, pop, done;
    logic [DW-1:0] word;
    acc    = vld && m_ready(ordy);
    pop    = m_vld && ordy;
    done   = 0;
    m_sync = 0;
    word   = '0;
    if (acc) begin
      if (sof) begin
        if (m_coll) m_sync = 1;
        m_frame.delete();
        m_frame.push_back(dat);
        m_coll = 1;
      end else if (m_coll) begin
        m_frame.push_back(dat);
        if (m_frame.size() == NSLOTS) begin
          done = 1;
          for (int k = 0; k < NUM_CH; k++) word[k*W +: W] = m_frame[k];
          m_dat = word;
          if (PARITY_EN) m_perr = (m_frame[NUM_CH][0] != ($countones(word) % 2 == 0));
          m_frame.delete();
          m_coll = 0;
        end
      end
    end
    if (done) m_vld = 1;
    else if (pop) m_vld = 0;
  endtask

  task automatic cycle(input bit vld, input bit sof, input logic [W-1:0] dat, input bit ordy);
    in_valid  = vld;
    in_sof    = sof;
    in_data   = dat;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready(ordy)));
    m_step(vld, sof, dat, ordy);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_data", 32'(out_data), 32'(m_dat));
    chk("sync_err", 32'(sync_err), 32'(m_sync));
`ifdef TDM_DEMUX_PARITY_EN
    if (m_vld) chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit            vld;
    bit            sof;
    logic [W-1:0]  dat;
    bit            ordy;
    bit            exp_rdy;
    bit            exp_ovld;
    logic [DW-1:0] exp_odat;
    bit            exp_sync;
  } vec_t;

  function automatic vec_t v(input bit vld, input bit sof, input bit dat, input bit ordy,
                             input bit rdy, input bit ovld, input logic [3:0] odat, input bit sync);
    vec_t r;
    r.vld = vld; r.sof = sof; r.dat = W'(dat); r.ordy = ordy;
    r.exp_rdy = rdy; r.exp_ovld = ovld; r.exp_odat = DW'(odat); r.exp_sync = sync;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_data", 32'(out_data), 32'd0);
    chk("init_sync_err", 32'(sync_err), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

`ifndef TDM_DEMUX_PARITY_EN
    // vld sof dat ordy | rdy ovld odat sync
    tbl.push_back(v(1,1,1,1, 1,0,4'h0,0));  // frame 1,0,1,1
    tbl.push_back(v(1,0,0,1, 1,0,4'h0,0));
    tbl.push_back(v(1,0,1,1, 1,0,4'h0,0));
    tbl.push_back(v(1,0,1,1, 1,1,4'hD,0));
    tbl.push_back(v(0,0,0,1, 1,0,4'hD,0));
    tbl.push_back(v(1,0,1,1, 1,0,4'hD,0));  // junk while hunting
    tbl.push_back(v(1,0,1,1, 1,0,4'hD,0));
    tbl.push_back(v(1,1,0,1, 1,0,4'hD,0));  // frame 0,1,1,0
    tbl.push_back(v(1,0,1,1, 1,0,4'hD,0));
    tbl.push_back(v(1,0,1,1, 1,0,4'hD,0));
    tbl.push_back(v(1,0,0,1, 1,1,4'h6,0));
    tbl.push_back(v(0,0,0,1, 1,0,4'h6,0));
    tbl.push_back(v(1,1,1,0, 1,0,4'h6,0));  // two frames with consumer stalled
    tbl.push_back(v(1,0,1,0, 1,0,4'h6,0));
    tbl.push_back(v(1,0,1,0, 1,0,4'h6,0));
    tbl.push_back(v(1,0,1,0, 1,1,4'hF,0));
    tbl.push_back(v(1,1,0,0, 1,1,4'hF,0));
    tbl.push_back(v(1,0,1,0, 1,1,4'hF,0));
    tbl.push_back(v(1,0,0,0, 1,1,4'hF,0));
    tbl.push_back(v(1,0,0,0, 0,1,4'hF,0));
    tbl.push_back(v(1,0,0,0, 0,1,4'hF,0));
    tbl.push_back(v(1,0,0,1, 1,1,4'h2,0));  // pop and load together
    tbl.push_back(v(0,0,0,1, 1,0,4'h2,0));
    tbl.push_back(v(1,1,1,1, 1,0,4'h2,0));  // two beats, then resync
    tbl.push_back(v(1,0,1,1, 1,0,4'h2,0));
    tbl.push_back(v(1,1,1,1, 1,0,4'h2,1));
    tbl.push_back(v(1,0,0,1, 1,0,4'h2,0));
    tbl.push_back(v(1,0,0,1, 1,0,4'h2,0));
    tbl.push_back(v(1,0,0,1, 1,1,4'h1,0));
    tbl.push_back(v(0,0,0,1, 1,0,4'h1,0));

    foreach (tbl[i]) begin
      in_valid  = tbl[i].vld;
      in_sof    = tbl[i].sof;
      in_data   = tbl[i].dat;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ovld));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_odat));
      chk($sformatf("vec%0d_sync_err", i), 32'(sync_err), 32'(tbl[i].exp_sync));
    end
`endif

    // Reset in the middle of a frame, then stray beats and a clean frame.
    do_reset();
    cycle(1, 1, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    do_reset();
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 1, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
`ifdef TDM_DEMUX_PARITY_EN
    cycle(1, 0, 1, 1);
`endif
    chk("post_reset_frame", 32'(out_data), 32'hF);
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    cycle(0, 0, 0, 1);

`ifdef TDM_DEMUX_PARITY_EN
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 0, 1);
    chk("par_ok_data", 32'(out_data), 32'hD);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    cycle(1, 1, 1, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);
    chk("par_bad_data", 32'(out_data), 32'hD);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    cycle(0, 0, 0, 1);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, W'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
Sequential time-division demultiplexer, the receive-side counterpart of the team's select-driven multiplexers. Accepts a serial stream of W-bit beats framed by a start-of-frame marker and steers slot k to output channel k. Publishes each complete frame as one parallel word through a valid/ready output holding register. Sits between a serialised link and parallel per-channel consumers.

Parameters:
NUM_CH, 4, number of channels (slots per frame); legal range 2..16
W, 1, data bits per slot/channel

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  beat present
in_ready  output  1  beat accepted when in_valid && in_ready
in_data  input  W  slot payload
in_sof  input  1  beat is slot 0 of a frame
out_valid  output  1  complete frame held
out_ready  input  1  consumer takes frame when out_valid && out_ready
out_data  output  NUM_CH*W  channel k at bits [k*W +: W]
sync_err  output  1  one-cycle pulse on mid-frame resync
parity_err  output  1  present only with TDM_DEMUX_PARITY_EN; qualifies out_valid

Behaviour:
- Reset (async, rst=1): state IDLE, slot_cnt 0, shadow regs 0, out_data 0, out_valid 0, sync_err 0, parity_err 0. Reset mid-frame discards the partial frame.
- States: IDLE (hunting sof) and COLLECT (slot_cnt = next slot index).
- IDLE: accepted beat with in_sof=0 is dropped silently. Accepted beat with in_sof=1 writes shadow[0], slot_cnt<=1, ->COLLECT.
- COLLECT, accepted beat with in_sof=0: writes shadow[slot_cnt], slot_cnt++. On the last slot (slot_cnt==LAST), the frame completes.
- Frame completion: on the next edge, out_data <= {beat, shadow[LAST-1..0]}, out_valid<=1, slot_cnt<=0, ->IDLE. Latency is 1 cycle from the final beat to out_valid.
- COLLECT, accepted beat with in_sof=1: the partial frame is abandoned. The beat becomes slot 0, slot_cnt<=1, state stays COLLECT, sync_err=1 for exactly one cycle.
- in_ready = !(state==COLLECT && slot_cnt==LAST && out_valid && !out_ready). It is low only while a completing beat has nowhere to go, and is combinational on out_ready.
- Output handshake: out_valid and out_data are held stable until out_valid && out_ready.
  - Pop with no new completion: out_valid<=0.
  - Pop and completion in the same cycle: out_data is replaced and out_valid stays 1 (no bubble).
- Slot counter width is clog2(NUM_CH+1). It wraps only via completion or resync, never by overflow.

Optional Feature:
TDM_DEMUX_PARITY_EN:
- Defined: each frame carries one extra trailing parity slot, so LAST = NUM_CH.
  - Parity beat in_data[0] must equal the XNOR-reduction of all NUM_CH*W data bits (1 when the count of ones is even).
  - parity_err is registered with out_data; it is 1 on mismatch and valid only while out_valid.
  - The frame is delivered regardless of parity result.
  - in_data[W-1:1] of the parity beat is ignored.
- Undefined: LAST = NUM_CH-1, no parity slot, and the parity_err port is absent.

Decomposition:
- Package tdm_pkg:
  - state typedef enum {IDLE, COLLECT}
  - function for counter width clog2(NUM_CH+1)
  - localparam for parity-slot presence derived from the macro
- Natural sub-module: tdm_slot_counter (load-1 on sof, increment on accept, clear on completion, last-slot flag). All else stays in tdm_demux.

Test Plan:
- NUM_CH=4, W=1, out_ready=1: beats sof,1 / 0 / 1 / 1 -> out_data=4'b1101, out_valid high one cycle after the 4th beat, for one cycle.
- IDLE with beats 1,1 at in_sof=0, then a valid frame 0,1,1,0 -> junk dropped; out_data=4'b0110; no sync_err.
- Hold out_ready=0 across two frames -> in_ready drops on the 4th beat of frame 2, first frame is held stable. Raise out_ready -> frame 1 pops, frame 2 loads in the same cycle, out_valid stays 1.
- After 2 beats of a frame, issue sof with beats 1,0,0,0 -> sync_err pulses one cycle; out_data=4'b0001.
- Assert rst after 3 beats, then send a full frame 1,1,1,1 -> all outputs 0 during reset; out_data=4'b1111 with no stale slot data.
- With TDM_DEMUX_PARITY_EN, data 1,0,1,1:
  - parity beat 0 -> parity_err=0
  - parity beat 1 -> parity_err=1
  - out_data=4'b1101 in both cases
